// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bus: redirect, instruction memory and decode handshake
interface fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;
    logic [31:0] fetch_count;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, fetch_count
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_pc_plus4, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with single outstanding request and redirect drain
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      reset,
    fetch_if.master   bus
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    // Address of the request on the bus while a stale fetch drains; pc_q then holds the redirect target.
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] redir_pc;

    assign redir_pc         = bus.redirect_pc & ~32'h3;
    assign bus.imem_req     = (state_q == REQ) || (state_q == DRAIN);
    assign bus.imem_addr    = (state_q == DRAIN) ? addr_q : pc_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.out_pc_plus4 = out_pc_q + 32'd4;
    assign bus.fetch_count  = count_q;

    // Next-state and datapath: redirect always overrides sequential pc+4 advance.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = (state_q == DRAIN) ? addr_q : pc_q;
        valid_d     = valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        count_d     = (valid_q && bus.out_ready) ? count_q + 32'd1 : count_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (bus.redirect_valid) pc_d = redir_pc;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    if (bus.redirect_valid) begin
                        pc_d = redir_pc;
                    end else begin
                        out_pc_d    = pc_q;
                        out_instr_d = bus.imem_rdata;
                        valid_d     = 1'b1;
                        state_d     = HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.redirect_valid) pc_d = redir_pc;
                if (bus.imem_ack) state_d = REQ;
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redir_pc;
                    state_d = REQ;
                end else if (bus.out_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            valid_q     <= 1'b0;
            out_pc_q    <= 32'd0;
            out_instr_q <= 32'd0;
            count_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fetch_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!bus.imem_req && n < 20) begin
            step();
            n++;
        end
        if (!bus.imem_req) chk("req_timeout", 32'd0, 32'd1);
    endtask

    // Waits for a request at addr, acks after gap cycles with data, checks presentation.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input int gap);
        wait_req();
        chk("req_addr", bus.imem_addr, addr);
        for (int i = 0; i < gap; i++) step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        step();
        bus.imem_ack   = 1'b0;
        chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("out_pc", bus.out_pc, addr);
        chk("out_instr", bus.out_instr, data);
        chk("out_pc_plus4", bus.out_pc_plus4, addr + 32'd4);
        chk("req_low_hold", {31'd0, bus.imem_req}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, 32'd0);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_pc"}, bus.out_pc, 32'd0);
        chk({tag, "_instr"}, bus.out_instr, 32'd0);
        chk({tag, "_pc4"}, bus.out_pc_plus4, 32'd4);
        chk({tag, "_count"}, bus.fetch_count, 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'd0;
        bus.out_ready      = 1'b1;
        #1;
        chk_reset_vals("rst");
        step();
        step();
        reset = 1'b1;
        chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);

        // Sequential fetch with zero-wait decode.
        fetch_one(32'h0, 32'hAAAA_0001, 1);
        fetch_one(32'h4, 32'hBBBB_0002, 1);
        fetch_one(32'h8, 32'hCCCC_0003, 1);
        step();
        chk("count3", bus.fetch_count, 32'd3);

        // Decode stall for 5 cycles.
        bus.out_ready = 1'b0;
        fetch_one(32'hC, 32'hDDDD_0004, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_pc", bus.out_pc, 32'hC);
            chk("stall_instr", bus.out_instr, 32'hDDDD_0004);
            chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
            chk("stall_count", bus.fetch_count, 32'd3);
        end
        bus.out_ready = 1'b1;
        step();
        chk("after_stall_addr", bus.imem_addr, 32'h10);
        chk("count4", bus.fetch_count, 32'd4);

        // Redirect while request waits: drain the stale fetch.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_req", {31'd0, bus.imem_req}, 32'd1);
            chk("drain_addr", bus.imem_addr, 32'h10);
            step();
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack   = 1'b0;
        chk("drop_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("redir_addr", bus.imem_addr, 32'h100);
        fetch_one(32'h100, 32'hEEEE_0005, 1);
        step();
        chk("count5", bus.fetch_count, 32'd5);

        // Redirect coincident with ack; low pc bits ignored.
        chk("pre_coinc_addr", bus.imem_addr, 32'h104);
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'h1234_5678;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h43;
        step();
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("coinc_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("coinc_req", {31'd0, bus.imem_req}, 32'd1);
        chk("coinc_addr", bus.imem_addr, 32'h40);
        chk("coinc_count", bus.fetch_count, 32'd5);

        // Two redirects during drain: last one wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_pc    = 32'h300;
        step();
        bus.redirect_valid = 1'b0;
        chk("drain2_addr", bus.imem_addr, 32'h40);
        bus.imem_ack = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        chk("last_wins_addr", bus.imem_addr, 32'h300);
        bus.out_ready = 1'b0;
        fetch_one(32'h300, 32'hFFFF_0006, 0);

        // Redirect in HOLD with a simultaneous handshake still counts.
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        chk("hold_redir_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("hold_redir_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk("count6", bus.fetch_count, 32'd6);

        // PC wrap at the top of the address space.
        fetch_one(32'hFFFF_FFFC, 32'h9999_0007, 0);
        chk("wrap_pc4", bus.out_pc_plus4, 32'h0);
        bus.out_ready = 1'b1;
        step();
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("count7", bus.fetch_count, 32'd7);
        fetch_one(32'h0, 32'h7777_0008, 0);
        step();
        chk("count8", bus.fetch_count, 32'd8);
        chk("mid_req", {31'd0, bus.imem_req}, 32'd1);
        chk("mid_addr", bus.imem_addr, 32'h4);

        // Asynchronous reset mid-request, late ack ignored.
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("arst");
        step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h5555_5555;
        reset = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post_rst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("post_rst_addr", bus.imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
